// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: load/store size encodings, MEM-stage FSM states
// and the bundle registered between MEM and write-back.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
  } wb_bundle_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
// Purely combinational; no handshake.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dmem_rdata[8*addr_lo +: 8];
  assign half_sel = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    wstrb     = 4'b1111;
    wdata     = rs2_data;
    load_data = dmem_rdata;
    case (funct3)
      F3_B, F3_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{rs2_data[7:0]}};
        load_data = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'h0, byte_sel};
      end
      F3_H, F3_HU: begin
        // Halfword lanes follow addr[1] only; addr[0] is either trapped or ignored.
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{rs2_data[15:0]}};
        load_data = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                     : {16'h0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage + MEM/WB register: 1 cycle zero-wait, 1+N with N dmem wait cycles; stalls upstream
// and inserts bubbles while dmem_ready is low. MISALIGN_TRAP_EN adds wb_misaligned trapping.
module memory_access_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_data,
  input  logic [4:0]  mem_rd,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [4:0]  wb_rd
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        wb_misaligned
`endif
);

  mem_state_t state, state_nxt;
  wb_bundle_t wb_q;
  logic       mem_op;
  logic       misaligned;
  logic [3:0] lane_wstrb;
  logic [31:0] load_ext;

  assign mem_op = mem_valid & (mem_MemRead | mem_MemWrite);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (mem_funct3)
      F3_H, F3_HU: misaligned = mem_alu_result[0];
      F3_W:        misaligned = |mem_alu_result[1:0];
      default:     misaligned = 1'b0;
    endcase
    misaligned = misaligned & mem_op;
  end
`else
  assign misaligned = 1'b0;
`endif

  assign dmem_req   = mem_op & ~misaligned;
  assign dmem_we    = dmem_req & mem_MemWrite;
  assign dmem_addr  = dmem_req ? {mem_alu_result[31:2], 2'b00} : 32'h0;
  assign dmem_wstrb = dmem_we ? lane_wstrb : 4'b0000;
  assign mem_stall  = dmem_req & ~dmem_ready;

  load_store_align u_align (
    .funct3     (mem_funct3),
    .addr_lo    (mem_alu_result[1:0]),
    .rs2_data   (mem_rs2_data),
    .dmem_rdata (dmem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (dmem_wdata),
    .load_data  (load_ext)
  );

  // A request that disappears while waiting can only come from a flush; drop back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (dmem_req && !dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready || !dmem_req) state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else if (mem_stall) begin
      wb_q.valid     <= 1'b0;
      wb_q.reg_write <= 1'b0;
    end else begin
      wb_q.valid      <= mem_valid;
      wb_q.reg_write  <= mem_RegWrite & mem_valid & ~misaligned;
      wb_q.mem_to_reg <= mem_MemtoReg;
      wb_q.alu_result <= mem_alu_result;
      wb_q.read_data  <= load_ext;
      wb_q.rd         <= mem_rd;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wb_misaligned <= 1'b0;
    else if (mem_stall) wb_misaligned <= 1'b0;
    else                wb_misaligned <= misaligned;
  end
`endif

  assign wb_valid      = wb_q.valid;
  assign wb_RegWrite   = wb_q.reg_write;
  assign wb_MemtoReg   = wb_q.mem_to_reg;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_read_data  = wb_q.read_data;
  assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, wait states, reset mid-access,
// pass-through ALU ops and the optional misalignment trap.
module tb_memory_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 0, mem_RegWrite = 0, mem_MemtoReg = 0, mem_MemRead = 0, mem_MemWrite = 0;
  logic [2:0]  mem_funct3 = 3'b0;
  logic [31:0] mem_alu_result = '0, mem_rs2_data = '0, dmem_rdata = '0;
  logic [4:0]  mem_rd = '0;
  logic        dmem_ready = 1'b0;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [31:0] wb_alu_result, wb_read_data;
  logic [4:0]  wb_rd;
`ifdef MISALIGN_TRAP_EN
  logic        wb_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_rd(wb_rd)
`ifdef MISALIGN_TRAP_EN
    , .wb_misaligned(wb_misaligned)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Applies one EX/MEM slot at the falling edge, then lets combinational outputs settle.
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic mr,
                       input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd,
                       input logic [31:0] rdata, input logic rdy);
    @(negedge clk);
    mem_valid = v; mem_RegWrite = rw; mem_MemtoReg = m2r; mem_MemRead = mr;
    mem_MemWrite = mw; mem_funct3 = f3; mem_alu_result = alu; mem_rs2_data = rs2;
    mem_rd = rd; dmem_rdata = rdata; dmem_ready = rdy;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_regwrite", wb_RegWrite, 1'b0);
    chk("rst_wb_alu", wb_alu_result, 32'h0);
    chk("rst_wb_rdata", wb_read_data, 32'h0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_wstrb", dmem_wstrb, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // LB 0x103, zero-wait
    drive(1, 1, 1, 1, 0, F3_B, 32'h103, 32'h0, 5'd7, 32'h80FF_1234, 1);
    chk("lb_stall", mem_stall, 1'b0);
    chk("lb_req", dmem_req, 1'b1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", dmem_we, 1'b0);
    edge_sample();
    chk("lb_rdata", wb_read_data, 32'hFFFF_FF80);
    chk("lb_memtoreg", wb_MemtoReg, 1'b1);
    chk("lb_valid", wb_valid, 1'b1);
    chk("lb_rd", wb_rd, 5'd7);

    // LHU 0x102 with two wait cycles
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 1, 0, F3_HU, 32'h102, 32'h0, 5'd9, 32'hBEEF_0000, 0);
      chk("lhu_stall", mem_stall, 1'b1);
      edge_sample();
      chk("lhu_bubble_rw", wb_RegWrite, 1'b0);
      chk("lhu_bubble_v", wb_valid, 1'b0);
      chk("lhu_state_wait", 32'(dut.state), 32'(MEM_WAIT));
    end
    drive(1, 1, 1, 1, 0, F3_HU, 32'h102, 32'h0, 5'd9, 32'hBEEF_0000, 1);
    chk("lhu_nostall", mem_stall, 1'b0);
    edge_sample();
    chk("lhu_rdata", wb_read_data, 32'h0000_BEEF);
    chk("lhu_valid", wb_valid, 1'b1);
    chk("lhu_state_idle", 32'(dut.state), 32'(MEM_IDLE));

    // SB 0x201, store with RegWrite=0
    drive(1, 0, 0, 0, 1, F3_B, 32'h201, 32'h1234_56AB, 5'd0, 32'h0, 1);
    chk("sb_we", dmem_we, 1'b1);
    chk("sb_addr", dmem_addr, 32'h200);
    chk("sb_wstrb", dmem_wstrb, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    edge_sample();
    chk("sb_wb_valid", wb_valid, 1'b1);
    chk("sb_wb_rw", wb_RegWrite, 1'b0);

    // SH 0x202
    drive(1, 0, 0, 0, 1, F3_H, 32'h202, 32'h0000_CAFE, 5'd0, 32'h0, 1);
    chk("sh_wstrb", dmem_wstrb, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hCAFE_CAFE);

    // LH 0x100 sign-extends, LBU 0x101 zero-extends
    drive(1, 1, 1, 1, 0, F3_H, 32'h100, 32'h0, 5'd3, 32'h0000_8001, 1);
    chk("lh_wstrb_idle", dmem_wstrb, 4'h0);
    edge_sample();
    chk("lh_rdata", wb_read_data, 32'hFFFF_8001);
    drive(1, 1, 1, 1, 0, F3_BU, 32'h101, 32'h0, 5'd4, 32'h0000_F000, 1);
    edge_sample();
    chk("lbu_rdata", wb_read_data, 32'h0000_00F0);

    // ADD pass-through; dmem_ready low must not stall it
    drive(1, 1, 0, 0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd5, 32'h0, 0);
    chk("add_req", dmem_req, 1'b0);
    chk("add_stall", mem_stall, 1'b0);
    chk("add_we", dmem_we, 1'b0);
    edge_sample();
    chk("add_alu", wb_alu_result, 32'hDEAD_BEEF);
    chk("add_rd", wb_rd, 5'd5);
    chk("add_rw", wb_RegWrite, 1'b1);
    chk("add_m2r", wb_MemtoReg, 1'b0);

    // Invalid slot: RegWrite masked
    drive(0, 1, 0, 1, 0, F3_W, 32'h400, 32'h0, 5'd6, 32'h0, 0);
    chk("inv_req", dmem_req, 1'b0);
    edge_sample();
    chk("inv_valid", wb_valid, 1'b0);
    chk("inv_rw", wb_RegWrite, 1'b0);

    // Reset during WAIT, then a fresh LW
    drive(1, 1, 1, 1, 0, F3_W, 32'h300, 32'h0, 5'd8, 32'h0, 0);
    edge_sample();
    chk("rstw_state_wait", 32'(dut.state), 32'(MEM_WAIT));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_state_idle", 32'(dut.state), 32'(MEM_IDLE));
    chk("rstw_wb_alu", wb_alu_result, 32'h0);
    chk("rstw_wb_rdata", wb_read_data, 32'h0);
    chk("rstw_wb_rd", wb_rd, 5'd0);
    chk("rstw_wb_m2r", wb_MemtoReg, 1'b0);
    drive(1, 1, 1, 1, 0, F3_W, 32'h300, 32'h0, 5'd8, 32'h1122_3344, 1);
    rst = 1'b0;
    #1;
    chk("lw_stall", mem_stall, 1'b0);
    edge_sample();
    chk("lw_rdata", wb_read_data, 32'h1122_3344);
    chk("lw_valid", wb_valid, 1'b1);
    chk("lw_rw", wb_RegWrite, 1'b1);

    // LW at 0x102: trapped or aligned down depending on build
    drive(1, 1, 1, 1, 0, F3_W, 32'h102, 32'h0, 5'd10, 32'hA5A5_5A5A, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", dmem_req, 1'b0);
    chk("mis_stall", mem_stall, 1'b0);
    edge_sample();
    chk("mis_flag", wb_misaligned, 1'b1);
    chk("mis_rw", wb_RegWrite, 1'b0);
    chk("mis_valid", wb_valid, 1'b1);
    drive(1, 1, 0, 0, 0, 3'b000, 32'h1, 32'h0, 5'd1, 32'h0, 0);
    edge_sample();
    chk("mis_clear", wb_misaligned, 1'b0);
`else
    chk("alw_addr", dmem_addr, 32'h100);
    chk("alw_stall", mem_stall, 1'b1);
    dmem_ready = 1'b1;
    #1;
    edge_sample();
    chk("alw_rdata", wb_read_data, 32'hA5A5_5A5A);
    chk("alw_rw", wb_RegWrite, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
